// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM that steps one instruction at a time through fetch/decode/exec/mem/wb on a shared memory port
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             branch_cond_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_o,
    output logic [2:0]       alu_op_o,
    output logic             extend_sel_o,
    output logic [1:0]       branch_type_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic             trap_o
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} stateE;
    stateE state, stateNext;
    logic [7:0] waitCnt;
    logic [CNT_W-1:0] count;
    logic memReq, memWe, iord, irWrite, pcWrite, regWrite, retire;
    logic [1:0] pcSrc;
    logic isR, isJ, isJal, isBranch, isAddi, isSltiu, isLui, isOri, isLw, isSw, toExec, fieldsOn;
    assign isR      = instr_op_i == 6'b000000;
    assign isJ      = instr_op_i == 6'b000010;
    assign isJal    = instr_op_i == 6'b000011;
    assign isBranch = instr_op_i[5:2] == 4'b0001;
    assign isAddi   = instr_op_i == 6'b001000;
    assign isSltiu  = instr_op_i == 6'b001011;
    assign isOri    = instr_op_i == 6'b001101;
    assign isLui    = instr_op_i == 6'b001111;
    assign isLw     = instr_op_i == 6'b100011;
    assign isSw     = instr_op_i == 6'b101011;
    assign toExec   = isR | isBranch | isAddi | isSltiu | isLui | isOri | isLw | isSw;
    assign fieldsOn = !rst_i && (state == DECODE || state == EXEC || state == MEM || state == WB);
    assign alu_op_o = !fieldsOn ? 3'b000 : (isAddi | isLw | isSw) ? 3'b001 : isSltiu ? 3'b010 :
                      isBranch ? 3'b011 : isLui ? 3'b100 : isOri ? 3'b101 : 3'b000;
    assign alu_src_o     = fieldsOn && (isAddi | isSltiu | isLui | isOri | isLw | isSw);
    assign reg_dst_o     = !fieldsOn ? 2'b00 : isR ? 2'b01 : isJal ? 2'b10 : 2'b00;
    assign mem_to_reg_o  = !fieldsOn ? 2'b00 : isLw ? 2'b01 : isJal ? 2'b11 : 2'b00;
    assign extend_sel_o  = fieldsOn && isOri;
    // opcode low bits 00/01/10/11 (beq/bne/blez/bgtz) remap to branch types 00/11/01/10
    assign branch_type_o = (fieldsOn && isBranch) ? {instr_op_i[0], instr_op_i[1] ^ instr_op_i[0]} : 2'b00;
    always_comb begin
        stateNext = state;
        memReq = 1'b0;
        memWe = 1'b0;
        iord = 1'b0;
        irWrite = 1'b0;
        pcWrite = 1'b0;
        pcSrc = 2'b00;
        regWrite = 1'b0;
        retire = 1'b0;
        case (state)
            FETCH: begin
                memReq = 1'b1;
                irWrite = mem_ready_i;
                pcWrite = mem_ready_i;
                stateNext = mem_ready_i ? DECODE : FETCH;
            end
            DECODE: begin
                pcWrite = isJ;
                pcSrc = isJ ? 2'b10 : 2'b00;
                retire = isJ;
                stateNext = isJ ? FETCH : isJal ? WB : toExec ? EXEC : TRAP;
            end
            EXEC: begin
                pcWrite = isBranch && branch_cond_i;
                pcSrc = isBranch ? 2'b01 : 2'b00;
                retire = isBranch;
                stateNext = isBranch ? FETCH : (isLw | isSw) ? MEM : WB;
            end
            MEM: begin
                memReq = 1'b1;
                iord = 1'b1;
                memWe = isSw;
                retire = mem_ready_i && isSw;
                stateNext = !mem_ready_i ? MEM : isSw ? FETCH : WB;
            end
            WB: begin
                regWrite = 1'b1;
                retire = 1'b1;
                pcWrite = isJal;
                pcSrc = isJal ? 2'b10 : 2'b00;
                stateNext = FETCH;
            end
            TRAP: stateNext = TRAP;
            default: stateNext = TRAP;
        endcase
        // ready on the last allowed cycle was already handled above and never reaches here
        if (memReq && !mem_ready_i && waitCnt == 8'(MAX_WAIT - 1))
            stateNext = TRAP;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
            waitCnt <= '0;
            count <= '0;
        end else begin
            state <= stateNext;
            waitCnt <= (stateNext != state) ? '0 : waitCnt + 8'(memReq && !mem_ready_i);
            count <= count + CNT_W'(retire);
        end
    end
    assign mem_req_o     = memReq && !rst_i;
    assign mem_we_o      = memWe && !rst_i;
    assign iord_o        = iord && !rst_i;
    assign ir_write_o    = irWrite && !rst_i;
    assign pc_write_o    = pcWrite && !rst_i;
    assign pc_src_o      = rst_i ? 2'b00 : pcSrc;
    assign reg_write_o   = regWrite && !rst_i;
    assign state_o       = rst_i ? 3'd0 : state;
    assign instr_count_o = rst_i ? '0 : count;
    assign trap_o        = !rst_i && state == TRAP;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and random instruction stream checked against a per-instruction path model
module tb_multicycle_ctrl;
    localparam int CW = 4;
    localparam int MW = 15;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
        OP_BNE = 6'b000101, OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111, OP_ADDI = 6'b001000,
        OP_SLTIU = 6'b001011, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
    typedef struct {logic [2:0] st; logic rdy; logic mem; logic pcw; logic [1:0] pcs; logic rw;} step_t;
    logic clk = 1'b0;
    logic rst, cond, ready;
    logic [5:0] op;
    logic mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, reg_write_o, alu_src_o, extend_sel_o, trap_o;
    logic [1:0] pc_src_o, reg_dst_o, mem_to_reg_o, branch_type_o;
    logic [2:0] alu_op_o, state_o;
    logic [CW-1:0] instr_count_o;
    logic [8:0] ctrl;
    logic [10:0] flds;
    logic [CW-1:0] expCount;
    int tests = 0;
    int fails = 0;
    logic [5:0] legalOps [13] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                                  OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI, OP_LW, OP_SW};

    multicycle_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .branch_cond_i(cond), .mem_ready_i(ready),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
        .pc_write_o(pc_write_o), .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .extend_sel_o(extend_sel_o),
        .branch_type_o(branch_type_o), .state_o(state_o), .instr_count_o(instr_count_o), .trap_o(trap_o)
    );

    always #5 clk = ~clk;
    assign ctrl = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, trap_o};
    assign flds = {alu_op_o, alu_src_o, reg_dst_o, mem_to_reg_o, extend_sel_o, branch_type_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // instruction classes: 0 ALU, 1 branch, 2 j, 3 jal, 4 lw, 5 sw, 6 illegal
    function automatic int cls(input logic [5:0] o);
        case (o)
            OP_R, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: return 0;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: return 1;
            OP_J: return 2;
            OP_JAL: return 3;
            OP_LW: return 4;
            OP_SW: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int lat(input int c);
        case (c)
            0: return 4;
            1: return 3;
            2: return 2;
            3: return 3;
            4: return 5;
            default: return 4;
        endcase
    endfunction

    // {alu_op, alu_src, reg_dst, mem_to_reg, extend_sel, branch_type}
    function automatic logic [10:0] fields(input logic [5:0] o);
        case (o)
            OP_R:     return {3'd0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00};
            OP_ADDI:  return {3'd1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00};
            OP_SLTIU: return {3'd2, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00};
            OP_ORI:   return {3'd5, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00};
            OP_LUI:   return {3'd4, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00};
            OP_LW:    return {3'd1, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00};
            OP_SW:    return {3'd1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00};
            OP_BEQ:   return {3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};
            OP_BNE:   return {3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11};
            OP_BLEZ:  return {3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01};
            OP_BGTZ:  return {3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10};
            OP_JAL:   return {3'd0, 1'b0, 2'b10, 2'b11, 1'b0, 2'b00};
            default:  return 11'd0;
        endcase
    endfunction

    function automatic step_t mk(input logic [2:0] st, input logic rdy, input logic mem,
                                 input logic pcw, input logic [1:0] pcs, input logic rw);
        return '{st, rdy, mem, pcw, pcs, rw};
    endfunction

    task automatic runInstr(input logic [5:0] opc, input int fw, input int mw, input logic c);
        step_t q[$];
        int k = cls(opc);
        int retAt = -1;
        for (int i = 0; i <= fw; i++) q.push_back(mk(3'd0, i == fw, 1'b1, i == fw, 2'd0, 1'b0));
        q.push_back(mk(3'd1, 1'b0, 1'b0, k == 2, k == 2 ? 2'd2 : 2'd0, 1'b0));
        if (k != 2 && k != 3) q.push_back(mk(3'd2, 1'b0, 1'b0, k == 1 && c, k == 1 ? 2'd1 : 2'd0, 1'b0));
        if (k >= 4) for (int i = 0; i <= mw; i++) q.push_back(mk(3'd3, i == mw, 1'b1, 1'b0, 2'd0, 1'b0));
        if (k == 0 || k == 3 || k == 4) q.push_back(mk(3'd4, 1'b0, 1'b0, k == 3, k == 3 ? 2'd2 : 2'd0, 1'b1));
        foreach (q[i]) begin
            op = (q[i].st == 3'd0) ? 6'($urandom) : opc;
            ready = q[i].mem ? q[i].rdy : 1'($urandom);
            cond = (k == 1 && q[i].st == 3'd2) ? c : 1'($urandom);
            @(negedge clk);
            chk("state", 32'(state_o), 32'(q[i].st));
            chk("ctrl", 32'(ctrl), 32'({q[i].mem, q[i].st == 3'd3 && k == 5, q[i].st == 3'd3,
                q[i].st == 3'd0 && q[i].rdy, q[i].pcw, q[i].pcs, q[i].rw, 1'b0}));
            chk("fields", 32'(flds), 32'(q[i].st == 3'd0 ? 11'd0 : fields(opc)));
            tick();
            if (retAt < 0 && instr_count_o !== expCount) retAt = i + 1;
        end
        expCount = expCount + 1'b1;
        chk("latency", 32'(retAt), 32'(lat(k) + fw + (k >= 4 ? mw : 0)));
        chk("count", 32'(instr_count_o), 32'(expCount));
    endtask

    task automatic trapCheck(input string tag);
        @(negedge clk);
        chk({tag, "-state"}, 32'(state_o), 32'd5);
        chk({tag, "-ctrl"}, 32'(ctrl), 32'd1);
        chk({tag, "-fields"}, 32'(flds), 32'd0);
        chk({tag, "-count"}, 32'(instr_count_o), 32'(expCount));
        tick();
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        ready = 1'($urandom);
        op = 6'($urandom);
        @(negedge clk);
        chk({tag, "-rstzero"}, 32'({ctrl, flds, state_o, instr_count_o}), 32'd0);
        tick();
        rst = 1'b0;
        expCount = '0;
        chk({tag, "-post"}, 32'({state_o, instr_count_o, trap_o}), 32'd0);
    endtask

    task automatic timeoutTest(input logic inMem);
        op = inMem ? OP_LW : OP_R;
        ready = 1'b1;
        if (inMem) repeat (3) tick();
        ready = 1'b0;
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            chk("to-state", 32'(state_o), inMem ? 32'd3 : 32'd0);
            chk("to-req", 32'(mem_req_o), 32'd1);
            tick();
        end
        trapCheck("to");
        doReset("to");
    endtask

    initial begin
        rst = 1'b1;
        op = '0;
        cond = 1'b0;
        ready = 1'b0;
        expCount = '0;
        tick();
        doReset("init");
        runInstr(OP_R, 0, 0, 1'b0);
        runInstr(OP_LW, 3, 2, 1'b0);
        runInstr(OP_BEQ, 0, 0, 1'b1);
        runInstr(OP_BNE, 0, 0, 1'b0);
        runInstr(OP_JAL, 0, 0, 1'b0);
        runInstr(OP_J, 1, 0, 1'b0);
        runInstr(OP_SW, 0, 1, 1'b0);
        runInstr(OP_ORI, MW - 1, 0, 1'b0);
        runInstr(OP_LW, 0, MW - 1, 1'b0);
        repeat (40) runInstr(legalOps[$urandom_range(0, 12)], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        ready = 1'b1;
        op = 6'($urandom);
        @(negedge clk);
        chk("ill-fetch", 32'(state_o), 32'd0);
        tick();
        op = 6'b111111;
        ready = 1'($urandom);
        @(negedge clk);
        chk("ill-decode", 32'(state_o), 32'd1);
        chk("ill-decode-out", 32'({ctrl, flds}), 32'd0);
        tick();
        repeat (20) begin
            ready = 1'($urandom);
            cond = 1'($urandom);
            op = 6'($urandom);
            trapCheck("ill");
        end
        doReset("ill");
        timeoutTest(1'b0);
        timeoutTest(1'b1);
        runInstr(OP_ADDI, 0, 0, 1'b0);
        op = OP_SW;
        ready = 1'b1;
        repeat (3) tick();
        ready = 1'b0;
        @(negedge clk);
        chk("sw-mem-state", 32'(state_o), 32'd3);
        chk("sw-mem-ctrl", 32'(ctrl), 32'b111000000);
        chk("sw-mem-count", 32'(instr_count_o), 32'(expCount));
        tick();
        doReset("sw");
        runInstr(OP_R, 0, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
